axil_gp_regfile: RTL and testbench

AXIL_GP_REGFILE -- requirements
Module: axil_gp_regfile

---
 rtl/axil_gp_regfile.sv | 163 ++++++++++++++++
 tb/tb_axil_gp_regfile.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_gp_regfile.sv
// AXI4-Lite general-purpose register file.
// Independent AW/W capture, strobed writes, per-register RO sources.
module axil_gp_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = ADDR_WIDTH - LSB;

  logic                  en;
  logic                  aw_held;
  logic                  w_held;
  logic [IW-1:0]         aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [IW-1:0]         widx;
  logic [IW-1:0]         ridx;
  logic [DATA_WIDTH-1:0] wd;
  logic [NB-1:0]         ws;
  logic                  w_ok;
  logic                  r_ok;
  logic [NUM_REGS-1:0]   w_sel;
  logic [DATA_WIDTH-1:0] r_val;
  logic                  unused;

  assign unused = ^{s_axi_awprot, s_axi_arprot,
                    s_axi_awaddr[LSB-1:0],
                    s_axi_araddr[LSB-1:0], reg_in};

  assign s_axi_awready = en & ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = en & ~w_held & ~s_axi_bvalid;
  assign s_axi_arready = en & ~s_axi_rvalid;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // A channel arriving this cycle completes the pair without being held.
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);
  assign widx   = aw_held ? aw_idx : s_axi_awaddr[ADDR_WIDTH-1:LSB];
  assign wd     = w_held ? w_data : s_axi_wdata;
  assign ws     = w_held ? w_strb : s_axi_wstrb;
  assign ridx   = s_axi_araddr[ADDR_WIDTH-1:LSB];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] =
      RO_MASK[g] ? reg_in[g*DATA_WIDTH +: DATA_WIDTH] : regs[g];
  end

  always_comb begin
    w_ok  = 1'b0;
    w_sel = '0;
    r_ok  = 1'b0;
    r_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(widx) == i && !RO_MASK[i]) begin
        w_ok     = 1'b1;
        w_sel[i] = 1'b1;
      end
      if (int'(ridx) == i) begin
        r_ok  = 1'b1;
        r_val = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (w_sel[i] && ws[b]) regs[i][b*8 +: 8] <= wd[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en           <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
      wr_pulse     <= '0;
    end else begin
      en       <= 1'b1;
      wr_pulse <= '0;
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= w_ok ? 2'b00 : 2'b10;
        wr_pulse     <= w_sel;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:LSB];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= s_axi_wdata;
          w_strb <= s_axi_wstrb;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= r_ok ? r_val : '0;
      s_axi_rresp  <= r_ok ? 2'b00 : 2'b10;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_gp_regfile.sv
// Randomized self-checking bench for axil_gp_regfile.
// Six 32-bit registers; register 5 is read-only, indices 6-7 unmapped.
module tb_axil_gp_regfile;

  localparam int NR = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [4:0]    araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [191:0]  reg_out;
  logic [191:0]  reg_in = '0;
  logic [NR-1:0] wr_pulse;

  int checks = 0;
  int errors = 0;
  int b_rises = 0;
  logic b_prev = 1'b0;
  logic [31:0] mdl [NR];

  axil_gp_regfile #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS(NR),
    .RO_MASK(6'h20)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out), .reg_in(reg_in),
    .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bvalid && !b_prev) b_rises++;
    b_prev = bvalid;
  end

  task automatic check(input string tag,
                       input logic [191:0] got,
                       input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] exp_vec();
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < NR; i++)
      v[i*32 +: 32] = (i == 5) ? reg_in[160 +: 32] : mdl[i];
    return v;
  endfunction

  task automatic mread(input logic [4:0] a,
                       output logic [31:0] d,
                       output logic [1:0] r);
    int idx;
    idx = int'(a[4:2]);
    if (idx >= NR) begin
      d = '0;
      r = 2'b10;
    end else begin
      d = (idx == 5) ? reg_in[160 +: 32] : mdl[idx];
      r = 2'b00;
    end
  endtask

  task automatic aw_send(input logic [4:0] a, input int dly);
    logic ok;
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a;
    awvalid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = awready;
      @(posedge clk);
      n++;
    end
    #1 awvalid = 1'b0;
    if (!ok) check("aw_timeout", ok, 1);
  endtask

  task automatic w_send(input logic [31:0] d,
                        input logic [3:0] s,
                        input int dly);
    logic ok;
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = wready;
      @(posedge clk);
      n++;
    end
    #1 wvalid = 1'b0;
    if (!ok) check("w_timeout", ok, 1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s,
                    input int awd, input int wd, input int bd);
    int idx;
    int r0;
    logic ok;
    logic [1:0] er;
    logic [NR-1:0] ep;
    idx = int'(a[4:2]);
    ok = (idx < 5);
    er = ok ? 2'b00 : 2'b10;
    ep = '0;
    if (ok) ep[idx] = 1'b1;
    r0 = b_rises;
    fork
      aw_send(a, awd);
      w_send(d, s, wd);
    join
    check("b_early", b_rises, r0);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, er);
    check("wr_pulse", wr_pulse, ep);
    if (ok)
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    check("reg_out", reg_out, exp_vec());
    for (int k = 0; k < bd; k++) begin
      @(negedge clk);
      check("b_hold", bvalid, 1);
      check("b_hold_resp", bresp, er);
      check("b_awready", awready, 0);
      check("b_wready", wready, 0);
      check("b_pulse", wr_pulse, (k == 0) ? ep : '0);
    end
    bready = 1'b1;
    @(posedge clk);
    #1 bready = 1'b0;
    check("b_clear", bvalid, 0);
    check("pulse_clear", wr_pulse, 0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] ed,
                    input logic [1:0] er, input int hd);
    logic ok;
    int n;
    araddr = a;
    arvalid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = arready;
      @(posedge clk);
      n++;
    end
    #1 arvalid = 1'b0;
    check("ar_hs", ok, 1);
    check("rvalid", rvalid, 1);
    check("rdata", rdata, ed);
    check("rresp", rresp, er);
    for (int k = 0; k < hd; k++) begin
      @(negedge clk);
      check("r_hold", rvalid, 1);
      check("r_hold_data", rdata, ed);
      check("r_hold_resp", rresp, er);
      check("r_arready", arready, 0);
    end
    rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
    check("r_clear", rvalid, 0);
  endtask

  task automatic rd_model(input logic [4:0] a, input int hd);
    logic [31:0] d;
    logic [1:0] r;
    mread(a, d, r);
    rd(a, d, r, hd);
  endtask

  initial begin
    logic [31:0] ed;
    logic [1:0] er;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    for (int i = 0; i < 6; i++) reg_in[i*32 +: 32] = $urandom;
    reg_in[160 +: 32] = 32'h12345678;

    #2;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_pulse", wr_pulse, 0);
    check("rst_regs", reg_out, exp_vec());
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("up_awready", awready, 1);
    check("up_wready", wready, 1);
    check("up_arready", arready, 1);

    wr(5'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    rd(5'h04, 32'hDEADBEEF, 2'b00, 0);

    wr(5'h08, 32'h0000AB00, 4'b0010, 3, 0, 0);
    rd(5'h08, 32'h0000AB00, 2'b00, 0);

    wr(5'h18, 32'hCAFEF00D, 4'hF, 0, 1, 0);
    rd(5'h1C, 32'h0, 2'b10, 0);

    wr(5'h14, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
    rd(5'h14, 32'h12345678, 2'b00, 0);

    wr(5'h00, 32'hA5A5A5A5, 4'b1001, 0, 2, 5);
    rd(5'h00, 32'hA50000A5, 2'b00, 5);

    mread(5'h08, ed, er);
    fork
      wr(5'h08, 32'h11223344, 4'hF, 0, 0, 0);
      rd(5'h08, ed, er, 0);
    join
    rd(5'h0A, 32'h11223344, 2'b00, 0);

    aw_send(5'h0C, 0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    check("mid_awready", awready, 0);
    check("mid_wready", wready, 0);
    check("mid_arready", arready, 0);
    check("mid_bvalid", bvalid, 0);
    check("mid_rvalid", rvalid, 0);
    check("mid_bresp", bresp, 0);
    check("mid_pulse", wr_pulse, 0);
    check("mid_regs", reg_out, exp_vec());
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    wr(5'h0C, 32'h0BADC0DE, 4'hF, 3, 0, 0);
    rd_model(5'h0C, 0);
    rd_model(5'h04, 0);

    for (int it = 0; it < 60; it++) begin
      reg_in[160 +: 32] = $urandom;
      wr(5'($urandom_range(0, 31)), $urandom,
         4'($urandom_range(0, 15)),
         $urandom_range(0, 3), $urandom_range(0, 3),
         $urandom_range(0, 2));
      rd_model(5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end
    for (int i = 0; i < 8; i++) rd_model(5'(i * 4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
